// File: rtl/ccff_bitstream_loader.sv
// Controller-side ccff loader: streams configuration words MSB-first onto a ccff chain head.
// Define CCFF_READBACK_EN to add a readback mode that rotates the chain once and returns its contents.
module ccff_bitstream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 40,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
`ifdef CCFF_READBACK_EN
  input  logic              rb_start,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
`ifdef CCFF_READBACK_EN
  localparam logic [1:0] READBACK = 2'd3;
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);
`endif

  // Bits of the next word that still belong to the chain; the tail word may be partial.
  function automatic logic [BC_W-1:0] load_bits(input logic [CNT_W-1:0] req);
    int rem;
    rem = CHAIN_LEN - int'(req);
    if (rem > DATA_W) rem = DATA_W;
    return BC_W'(rem);
  endfunction

  logic [1:0]        state;
  logic [DATA_W-1:0] shift_buf;
  logic [BC_W-1:0]   buf_cnt;
  logic [BC_W-1:0]   load_n;
  logic [CNT_W-1:0]  bits_done;
  logic [CNT_W-1:0]  bits_req;
  logic              head_q;
  logic              shift_q;
  logic              shift;
  logic              accept;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_sr;
  logic [DATA_W-1:0] rb_next;
  logic [BC_W-1:0]   rb_cnt;

  assign rb_next       = {rb_sr[DATA_W-2:0], ccff_tail};
  assign ccff_head     = (state == READBACK) ? ccff_tail : head_q;
  assign ccff_shift_en = (state == READBACK) | shift_q;
`else
  logic unused_tail;

  assign unused_tail   = ccff_tail;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_q;
`endif

  assign shift      = (state == LOAD) && (buf_cnt != '0);
  assign word_ready = (state == LOAD) && (bits_req < LEN) &&
                      ((buf_cnt == '0) || ((buf_cnt == BC_W'(1)) && shift));
  assign accept     = word_valid && word_ready;
  assign load_n     = load_bits(bits_req);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      buf_cnt   <= '0;
      bits_done <= '0;
      bits_req  <= '0;
      head_q    <= 1'b0;
      shift_q   <= 1'b0;
`ifdef CCFF_READBACK_EN
      rb_cnt    <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
`endif
    end else begin
`ifdef CCFF_READBACK_EN
      rb_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          shift_q <= 1'b0;
          if (start) begin
            state     <= LOAD;
            bits_done <= '0;
            bits_req  <= '0;
            buf_cnt   <= '0;
          end
`ifdef CCFF_READBACK_EN
          else if (rb_start) begin
            state     <= READBACK;
            bits_done <= '0;
            rb_cnt    <= '0;
          end
`endif
        end
        LOAD: begin
          shift_q <= shift;
          if (shift) begin
            head_q    <= shift_buf[DATA_W-1];
            bits_done <= bits_done + CNT_W'(1);
          end
          // A refill on the last buffered bit overrides the decrement, giving bubble-free words.
          if (accept) begin
            buf_cnt  <= load_n;
            bits_req <= bits_req + CNT_W'(load_n);
          end else if (shift) begin
            buf_cnt <= buf_cnt - BC_W'(1);
          end
          if (bits_done == LEN) state <= FINISH;
        end
        FINISH: begin
          shift_q <= 1'b0;
          state   <= IDLE;
        end
`ifdef CCFF_READBACK_EN
        READBACK: begin
          bits_done <= bits_done + CNT_W'(1);
          if (rb_cnt == BC_W'(DATA_W - 1)) begin
            rb_data  <= rb_next;
            rb_valid <= 1'b1;
            rb_cnt   <= '0;
          end else if (bits_done == LEN_M1) begin
            // Final partial word: left-align the collected bits, zero below.
            rb_data  <= rb_next << (BC_W'(DATA_W - 1) - rb_cnt);
            rb_valid <= 1'b1;
          end else begin
            rb_cnt <= rb_cnt + BC_W'(1);
          end
          if (bits_done == LEN_M1) state <= FINISH;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (state == LOAD) begin
      if (accept)     shift_buf <= word_data;
      else if (shift) shift_buf <= shift_buf << 1;
    end
`ifdef CCFF_READBACK_EN
    if (state == READBACK) rb_sr <= rb_next;
`endif
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 10-bit and a 40-bit chain, each with a behavioural shift-chain model.
module tb_ccff_bitstream_loader;

  typedef struct {
    int          k;
    int          nw;
    logic [47:0] words;
    int          stall;
    int          restart;
    logic [39:0] img;
    int          acc;
    int          nsh;
    int          gap;
  } row_t;

  logic        prog_clk;
  logic        p_reset;
  logic        clr;
  logic        starts [2];
  logic        valids [2];
  logic [7:0]  datas  [2];
  logic        readys [2];
  logic        heads  [2];
  logic        ens    [2];
  logic        tails  [2];
  logic        busys  [2];
  logic        dones  [2];
  logic [39:0] chain  [2] = '{40'h0, 40'h0};
  logic        last_head [2];
  int          nsh [2], acc_cnt [2], done_cnt [2], hold_err [2];
  int          first_sh [2], last_sh [2], done_cyc [2];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  row_t        tbl [4];
  logic [39:0] img;
  logic [47:0] sh;

  assign tails[0] = chain[0][9];
  assign tails[1] = chain[1][39];

`ifdef CCFF_READBACK_EN
  logic        rb_start;
  logic [7:0]  rb_data;
  logic        rb_valid;
  logic [7:0]  unused_rb_data10;
  logic        unused_rb_valid10;
  logic [7:0]  rb_got [8];
  int          rb_n;
`endif

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(10)) dut10 (
    .prog_clk(prog_clk), .pReset(p_reset), .start(starts[0]),
    .word_data(datas[0]), .word_valid(valids[0]), .word_ready(readys[0]),
    .ccff_head(heads[0]), .ccff_shift_en(ens[0]), .ccff_tail(tails[0]),
`ifdef CCFF_READBACK_EN
    .rb_start(1'b0), .rb_data(unused_rb_data10), .rb_valid(unused_rb_valid10),
`endif
    .busy(busys[0]), .done(dones[0])
  );

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(40)) dut40 (
    .prog_clk(prog_clk), .pReset(p_reset), .start(starts[1]),
    .word_data(datas[1]), .word_valid(valids[1]), .word_ready(readys[1]),
    .ccff_head(heads[1]), .ccff_shift_en(ens[1]), .ccff_tail(tails[1]),
`ifdef CCFF_READBACK_EN
    .rb_start(rb_start), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .busy(busys[1]), .done(dones[1])
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Chain models plus per-DUT event counters, sampled on the active edge.
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (ens[k]) chain[k] <= {chain[k][38:0], heads[k]};
      last_head[k] <= heads[k];
      if (clr) begin
        nsh[k] <= 0; acc_cnt[k] <= 0; done_cnt[k] <= 0; hold_err[k] <= 0;
        first_sh[k] <= 0; last_sh[k] <= 0; done_cyc[k] <= 0;
      end else begin
        if (ens[k]) begin
          if (nsh[k] == 0) first_sh[k] <= cyc;
          last_sh[k] <= cyc;
          nsh[k] <= nsh[k] + 1;
        end
        if (valids[k] && readys[k]) acc_cnt[k] <= acc_cnt[k] + 1;
        if (dones[k]) begin
          done_cnt[k] <= done_cnt[k] + 1;
          done_cyc[k] <= cyc;
        end
        if (busys[k] && !ens[k] && (heads[k] !== last_head[k])) hold_err[k] <= hold_err[k] + 1;
      end
    end
`ifdef CCFF_READBACK_EN
    if (clr) rb_n <= 0;
    else if (rb_valid && rb_n < 8) begin
      rb_got[rb_n] <= rb_data;
      rb_n <= rb_n + 1;
    end
`endif
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    @(posedge prog_clk); #1;
    clr = 1'b0;
  endtask

  task automatic do_load(input int k, input int nw, input logic [47:0] words,
                         input int stall, input int restart);
    int idx;
    int st;
    logic a;
    logic [47:0] w;
    idx = 0;
    st = stall;
    starts[k] = 1'b1;
    @(posedge prog_clk); #1;
    starts[k] = 1'b0;
    for (int n = 0; n < 200 && busys[k]; n++) begin
      starts[k] = (n == restart);
      w = words << (8 * idx);
      datas[k] = w[47:40];
      valids[k] = (idx < nw);
      if (idx == 1 && st > 0 && readys[k]) begin
        valids[k] = 1'b0;
        st--;
      end
      a = valids[k] && readys[k];
      @(posedge prog_clk); #1;
      if (a) idx++;
    end
    starts[k] = 1'b0;
    valids[k] = 1'b0;
    chk("load_end_busy", 64'(busys[k]), 64'(0));
  endtask

  task automatic run_row(input row_t r);
    logic [39:0] got;
    clear();
    do_load(r.k, r.nw, r.words, r.stall, r.restart);
    got = (r.k == 0) ? {30'd0, chain[0][9:0]} : chain[1];
    chk("chain_image", 64'(got), 64'(r.img));
    chk("words_accepted", 64'(acc_cnt[r.k]), 64'(r.acc));
    chk("shift_count", 64'(nsh[r.k]), 64'(r.nsh));
    chk("shift_gap", 64'(last_sh[r.k] - first_sh[r.k] + 1 - nsh[r.k]), 64'(r.gap));
    chk("done_pulses", 64'(done_cnt[r.k]), 64'(1));
    chk("done_after_last_shift", 64'(done_cyc[r.k] - last_sh[r.k]), 64'(1));
    chk("head_held_in_stall", 64'(hold_err[r.k]), 64'(0));
  endtask

  initial begin
    int idx;
    logic a;
    tbl[0] = '{k:0, nw:3, words:48'hA5C0FF000000, stall:0, restart:-1,
               img:40'h297, acc:2, nsh:10, gap:0};
    tbl[1] = '{k:0, nw:3, words:48'hA5C0FF000000, stall:5, restart:-1,
               img:40'h297, acc:2, nsh:10, gap:5};
    tbl[2] = '{k:1, nw:6, words:48'h3C91E7086B55, stall:0, restart:-1,
               img:40'h3C91E7086B, acc:5, nsh:40, gap:0};
    tbl[3] = '{k:1, nw:6, words:48'h123456789AAA, stall:3, restart:15,
               img:40'h123456789A, acc:5, nsh:40, gap:3};

    p_reset = 1'b1;
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      starts[k] = 1'b0; valids[k] = 1'b0; datas[k] = 8'h00;
    end
`ifdef CCFF_READBACK_EN
    rb_start = 1'b0;
`endif
    repeat (2) @(posedge prog_clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", 64'({readys[k], heads[k], ens[k], busys[k], dones[k]}), 64'(0));
    p_reset = 1'b0;
    clear();

    // Words presented in IDLE must be refused.
    for (int n = 0; n < 3; n++) begin
      valids[1] = 1'b1;
      datas[1] = 8'hAA;
      chk("idle_ready", 64'(readys[1]), 64'(0));
      @(posedge prog_clk); #1;
    end
    valids[1] = 1'b0;
    chk("idle_accepts", 64'(acc_cnt[1]), 64'(0));
    chk("idle_busy", 64'(busys[1]), 64'(0));

    for (int i = 0; i < 4; i++) run_row(tbl[i]);

    // Reset after 17 shifts aborts the load with no done pulse.
    clear();
    starts[1] = 1'b1;
    @(posedge prog_clk); #1;
    starts[1] = 1'b0;
    idx = 0;
    for (int n = 0; n < 100 && nsh[1] < 17; n++) begin
      sh = 48'hC3A55A3CF00F << (8 * idx);
      datas[1] = sh[47:40];
      valids[1] = 1'b1;
      a = readys[1];
      @(posedge prog_clk); #1;
      if (a) idx++;
    end
    chk("shifts_before_reset", 64'(nsh[1]), 64'(17));
    p_reset = 1'b1;
    #1;
    chk("mid_load_reset_outputs", 64'({readys[1], heads[1], ens[1], busys[1], dones[1]}), 64'(0));
    valids[1] = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("mid_load_reset_no_done", 64'(done_cnt[1]), 64'(0));
    p_reset = 1'b0;
    run_row(tbl[2]);

`ifdef CCFF_READBACK_EN
    clear();
    do_load(1, 5, 48'hDEADBEEF5A00, 0, -1);
    img = chain[1];
    chk("rb_loaded_image", 64'(img), 64'(40'hDEADBEEF5A));
    clear();
    rb_start = 1'b1;
    @(posedge prog_clk); #1;
    rb_start = 1'b0;
    for (int n = 0; n < 200 && busys[1]; n++) begin
      @(posedge prog_clk); #1;
    end
    chk("rb_end_busy", 64'(busys[1]), 64'(0));
    chk("rb_word_count", 64'(rb_n), 64'(5));
    for (int i = 0; i < 5; i++) begin
      sh = 48'hDEADBEEF5A00 << (8 * i);
      chk("rb_word", 64'(rb_got[i]), 64'(sh[47:40]));
    end
    chk("rb_done_pulses", 64'(done_cnt[1]), 64'(1));
    chk("rb_shift_count", 64'(nsh[1]), 64'(40));
    chk("rb_chain_unchanged", 64'(chain[1]), 64'(img));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
